// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_CLEAN = 2'd0,
        RELEASE    = 2'd1,
        RUN        = 2'd2
    } state_e;

    // Bits needed to hold a counter whose terminal value is max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of the stage index, which counts 0..num_out.
    function automatic int stage_idx_width(input int num_out);
        return cnt_width(num_out);
    endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 by reset.
module rst_sequencer_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "rst_sequencer_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync_q;

    // Shift the input through the chain; the last flop is the safe copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: debounces lock/pad reset, then releases NUM_OUT
// active-low resets one after another, and tears them all down on a fault
// or a software request.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_OUT         = 3,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int STAGE_DELAY     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               locked_i,
    input  logic               ext_rst_i,
    input  logic               sw_rst_req_i,
    input  logic               lock_lost_clr_i,
    output logic [NUM_OUT-1:0] rst_no,
    output logic               ready_o,
    output logic               lock_lost_o
);

    if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
        $fatal(1, "rst_sequencer: NUM_OUT must be 1..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "rst_sequencer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "rst_sequencer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_delay
        $fatal(1, "rst_sequencer: STAGE_DELAY must be >= 1");
    end

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int TW = cnt_width(STAGE_DELAY);
    localparam int IW = stage_idx_width(NUM_OUT);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] SD_LAST  = TW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(NUM_OUT);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    // rst_ni asserts asynchronously; its release is retimed to clk_i here so
    // every flop below leaves reset on the same edge.
    logic [1:0] rsync_q;
    logic       arst_n;

    // Two-flop reset release synchroniser.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsync_q <= 2'b00;
        else         rsync_q <= {rsync_q[0], 1'b1};
    end

    assign arst_n = rsync_q[1];

    logic locked_s;
    logic ext_s;

    rst_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk_i  (clk_i),
        .rst_ni (arst_n),
        .d_i    (locked_i),
        .q_o    (locked_s)
    );

    rst_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk_i  (clk_i),
        .rst_ni (arst_n),
        .d_i    (ext_rst_i),
        .q_o    (ext_s)
    );

    state_e             state_q, state_d;
    logic [DW-1:0]      deb_q, deb_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               ready_q, ready_d;
    logic               lost_q, lost_d;
    logic               fault;

    assign fault = !locked_s || ext_s;

    // State and datapath registers; every output comes straight from here.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= WAIT_CLEAN;
            deb_q   <= '0;
            tmr_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state: debounce, staged release, and fault/software teardown.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        unique case (state_q)
            WAIT_CLEAN: begin
                rst_d   = '0;
                ready_d = 1'b0;
                tmr_d   = '0;
                idx_d   = '0;
                if (fault) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    // Terminal count reached on this edge: start releasing.
                    deb_d   = '0;
                    state_d = RELEASE;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (fault) begin
                    // Fault beats a coincident software request.
                    rst_d   = '0;
                    ready_d = 1'b0;
                    deb_d   = '0;
                    tmr_d   = '0;
                    idx_d   = '0;
                    state_d = WAIT_CLEAN;
                end else if (state_q == RUN && sw_rst_req_i) begin
                    // Drop everything for one cycle, then re-release at once.
                    rst_d   = '0;
                    ready_d = 1'b0;
                    tmr_d   = '0;
                    idx_d   = '0;
                    state_d = RELEASE;
                end else if (state_q == RELEASE) begin
                    if (idx_q == '0) begin
                        rst_d[0] = 1'b1;
                        idx_d    = IDX_ONE;
                        tmr_d    = '0;
                    end else if (idx_q == IDX_END) begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end else if (tmr_q == SD_LAST) begin
                        for (int i = 1; i < NUM_OUT; i++) begin
                            if (idx_q == IW'(i)) rst_d[i] = 1'b1;
                        end
                        idx_d = idx_q + 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end

            default: begin
                rst_d   = '0;
                ready_d = 1'b0;
                deb_d   = '0;
                tmr_d   = '0;
                idx_d   = '0;
                state_d = WAIT_CLEAN;
            end
        endcase
    end

    // Sticky lock-loss flag; a new loss wins over a same-cycle clear.
    always_comb begin
        lost_d = lost_q && !lock_lost_clr_i;
        if ((state_q == RELEASE || state_q == RUN) && !locked_s) lost_d = 1'b1;
    end

    assign rst_no      = rst_q;
    assign ready_o     = ready_q;
    assign lock_lost_o = lost_q;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 3: number of staged reset outputs (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 3: synchroniser depth for async inputs (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1024: consecutive clean cycles required before release (>=1).
REQ-004 SHALL have parameter STAGE_DELAY, default 16: cycles between successive stage releases (>=1).
REQ-005 SHALL have port clk_i, input, 1: the single clock, free-running (MMCM/BUFG output).
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port locked_i, input, 1: PLL/MMCM lock, asynchronous to clk_i.
REQ-008 SHALL have port ext_rst_i, input, 1: active-high pad reset, asynchronous.
REQ-009 SHALL have port sw_rst_req_i, input, 1: synchronous single-cycle software reset request.
REQ-010 SHALL have port lock_lost_clr_i, input, 1: synchronous clear of the sticky lock-loss flag.
REQ-011 SHALL have port rst_no, output, NUM_OUT: staged active-low resets; index 0 releases first.
REQ-012 SHALL have port ready_o, output, 1: high when all stages are released.
REQ-013 SHALL have port lock_lost_o, output, 1: sticky flag for lock loss while in RUN or RELEASE.

Function
REQ-014 SHALL pass locked_i and ext_rst_i through SYNC_STAGES-flop synchronisers (locked_s, ext_s) before any use.
REQ-015 SHALL implement FSM states WAIT_CLEAN, RELEASE and RUN; reset state is WAIT_CLEAN.
REQ-016 WAIT_CLEAN SHALL count cycles with locked_s=1 and ext_s=0; any violation clears the counter to 0.
REQ-017 WAIT_CLEAN SHALL go to RELEASE on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-018 RELEASE SHALL raise rst_no[0] one cycle after entry and rst_no[i] exactly i*STAGE_DELAY cycles after rst_no[0].
REQ-019 SHALL enter RUN and raise ready_o one cycle after rst_no[NUM_OUT-1] rises.
REQ-020 In RELEASE or RUN, locked_s=0 or ext_s=1 SHALL drive all rst_no low and ready_o low on the next edge, clear the counters and return to WAIT_CLEAN.
REQ-021 Lock loss (locked_s 1->0) in RELEASE or RUN SHALL set lock_lost_o; lock_lost_clr_i clears it; set wins if both occur in the same cycle.
REQ-022 In RUN, sw_rst_req_i SHALL drive all rst_no and ready_o low on the next edge, then re-enter RELEASE without debounce, so rst_no[0] is low for exactly 1 cycle.
REQ-023 sw_rst_req_i SHALL be ignored in WAIT_CLEAN and RELEASE; a fault (REQ-020) coinciding with sw_rst_req_i takes priority.
REQ-024 All outputs SHALL be driven directly from flops (glitch-free); a released rst_no[i] stays high until a fault or software reset.
REQ-025 Counter widths SHALL be $clog2(max+1) of their terminal value, with no wrap: counters saturate or clear on a state change.
REQ-026 Illegal parameter values SHALL stop elaboration via an assertion.

Reset
REQ-027 rst_ni low SHALL asynchronously force rst_no=0, ready_o=0, lock_lost_o=0, the synchronisers to 0, the counters to 0 and the state to WAIT_CLEAN.
REQ-028 rst_ni low mid-RELEASE SHALL re-assert any already-released stages immediately (asynchronously).
REQ-029 Reset deassertion SHALL be synchronous to clk_i; the first active edge evaluates from WAIT_CLEAN.

Structure
REQ-030 The FSM state enum and stage index width function SHALL live in package rst_sequencer_pkg.
REQ-031 The synchroniser SHALL be sub-module rst_sequencer_sync (parameter STAGES, async active-low clear), instantiated twice.

Verification (NUM_OUT=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, STAGE_DELAY=4, ext_rst_i=0; edge 0 = locked_i rise)
REQ-032 Power-up: rst_no[0] rises at edge 11, rst_no[1] at 15, rst_no[2] at 19, and ready_o at 20.
REQ-033 Debounce restart: locked_i glitches low for 3 cycles at edge 5, then is stable; the counter restarts and rst_no[0] rises 8+1 cycles after locked_s returns high.
REQ-034 Lock loss in RUN: locked_i falls; all rst_no go low and ready_o goes low 2+1 edges later; lock_lost_o=1 holds until lock_lost_clr_i, and re-release follows the REQ-032 timing.
REQ-035 Software reset in RUN: a 1-cycle sw_rst_req_i drives rst_no=000 next edge, rst_no[0] high 1 edge later, then +4 and +8 for stages 1 and 2; lock_lost_o stays 0.
REQ-036 ext_rst_i pulse during RELEASE (after rst_no[0] is released): all outputs go low, the FSM returns to WAIT_CLEAN, and the full debounce repeats after ext_rst_i falls.
REQ-037 rst_ni asserted mid-RELEASE: all outputs are 0 with no clock edge; after release the REQ-032 sequence repeats.
